// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add 32x32->64 multiplier that borrows the shared ALU for every add/subtract step.
// Optional MUL_SIGNED_EN adds the two-step two's-complement correction (FIX_A/FIX_B) after CALC.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             alu_own_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  output logic             alu_cin_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_cout_i
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       CTRL_OFF = 4'b0000;
  localparam logic [3:0]       CTRL_ADD = 4'b0010;

`ifdef MUL_SIGNED_EN
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  typedef enum logic [2:0] {IDLE, CALC, FIX_A, FIX_B, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

`ifdef MUL_SIGNED_EN
  logic [WIDTH-1:0] mplier;
  logic             neg_a;
  logic             neg_b;
  logic             sgn;
`else
  logic             unused_signed;
  assign unused_signed = signed_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
`ifdef MUL_SIGNED_EN
      mplier <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      sgn    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            mcand  <= src1_i;
            lo     <= src2_i;
            hi     <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= CALC;
`ifdef MUL_SIGNED_EN
            mplier <= src2_i;
            sgn    <= signed_i;
            neg_a  <= signed_i & src1_i[WIDTH-1];
            neg_b  <= signed_i & src2_i[WIDTH-1];
`endif
          end
        end
        CALC: begin
          // {cout, result, lo} is the 65-bit partial product, shifted right one place
          hi  <= {alu_cout_i, alu_result_i[WIDTH-1:1]};
          lo  <= {alu_result_i[0], lo[WIDTH-1:1]};
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
            if (sgn) begin
              state <= FIX_A;
            end else begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
`else
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        FIX_A: begin
          hi    <= alu_result_i;
          state <= FIX_B;
        end
        FIX_B: begin
          hi     <= alu_result_i;
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ALU operand/control muxes are decoded from registered state only
  always_comb begin
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_ctrl_o = CTRL_OFF;
    alu_cin_o  = 1'b0;
    case (state)
      CALC: begin
        alu_src1_o = hi;
        alu_src2_o = lo[0] ? mcand : '0;
        alu_ctrl_o = CTRL_ADD;
      end
`ifdef MUL_SIGNED_EN
      // Signed product = unsigned product - 2^W * (neg_a*B + neg_b*A)
      FIX_A: begin
        alu_src1_o = hi;
        alu_src2_o = neg_a ? mplier : '0;
        alu_ctrl_o = CTRL_SUB;
        alu_cin_o  = 1'b1;
      end
      FIX_B: begin
        alu_src1_o = hi;
        alu_src2_o = neg_b ? mcand : '0;
        alu_ctrl_o = CTRL_SUB;
        alu_cin_o  = 1'b1;
      end
`endif
      default: begin
        alu_src1_o = '0;
      end
    endcase
  end

  assign alu_own_o = busy_o;
  assign hi_o      = hi;
  assign lo_o      = lo;

endmodule
